// File: rtl/byte_merger_if.sv
// -----------------------------------------------------------------------------
// byte_merger_if
// Handshake bundle between a byte-serial source, the byte merger and a
// word-wide sink.
//   in_byte / in_valid / in_ready       byte stream into the merger
//   flush                               request to emit the partial word now
//   out_word / out_nbytes / out_valid   assembled word towards the sink
//   out_ready                           sink accepts out_word
// Modports:
//   slave  - view of the merger itself
//   master - view of the environment (byte source plus word sink)
// -----------------------------------------------------------------------------
interface byte_merger_if #(
  parameter int N_BYTES = 4,
  parameter int CNT_W   = 3
) ();

  logic [7:0]           in_byte;
  logic                 in_valid;
  logic                 in_ready;
  logic                 flush;
  logic [8*N_BYTES-1:0] out_word;
  logic [CNT_W-1:0]     out_nbytes;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_byte, in_valid, flush, out_ready,
    output in_ready, out_word, out_nbytes, out_valid
  );

  modport master (
    output in_byte, in_valid, flush, out_ready,
    input  in_ready, out_word, out_nbytes, out_valid
  );

endinterface

// File: rtl/byte_merger.sv
// -----------------------------------------------------------------------------
// byte_merger
// Packs a valid/ready byte stream into N_BYTES-wide words, first byte in the
// most significant lane. A flush request emits the partial word zero-padded,
// together with its byte count.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    byte_merger_if.slave (byte input, flush, word output handshakes)
// -----------------------------------------------------------------------------
module byte_merger #(
  parameter int N_BYTES = 4,
  parameter int CNT_W   = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  byte_merger_if.slave  bus
);

  localparam int W = 8 * N_BYTES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_t;

  slot_t            slot_r, slot_nxt_s;
  logic [W-1:0]     acc_r, acc_nxt_s, acc_ins_s;
  logic [W-1:0]     out_word_r, out_word_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s, nbytes_s;
  logic [CNT_W-1:0] out_nbytes_r, out_nbytes_nxt_s;
  logic             in_ready_s, in_accept_s, out_take_s;
  logic             complete_s, flush_eff_s, emit_s;

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = (slot_r == SLOT_FULL);
  assign bus.out_word   = out_word_r;
  assign bus.out_nbytes = out_nbytes_r;

  // Handshake qualifiers and the word-emit decision.
  always_comb begin
    // The slot can take a byte whenever it is empty or draining this cycle.
    in_ready_s  = (slot_r == SLOT_EMPTY) | bus.out_ready;
    in_accept_s = bus.in_valid & in_ready_s;
    out_take_s  = (slot_r == SLOT_FULL) & bus.out_ready;
    complete_s  = in_accept_s & (count_r == LAST_CNT);
    // Flush only counts when there is something to emit and the slot is free.
    flush_eff_s = bus.flush & in_ready_s & ((count_r != {CNT_W{1'b0}}) | in_accept_s);
    emit_s      = complete_s | flush_eff_s;
    nbytes_s    = count_r + {{(CNT_W-1){1'b0}}, in_accept_s};
  end

  // Accumulator view with this cycle's byte (if any) dropped into its lane.
  always_comb begin
    acc_ins_s = acc_r;
    for (int i = 0; i < N_BYTES; i++) begin
      // Lane N_BYTES-1 is filled first so the first byte ends up on top.
      if (in_accept_s && (count_r == CNT_W'(N_BYTES - 1 - i))) begin
        acc_ins_s[8*i +: 8] = bus.in_byte;
      end else begin
        acc_ins_s[8*i +: 8] = acc_r[8*i +: 8];
      end
    end
  end

  // Next-state logic for fill state and the output slot.
  always_comb begin
    acc_nxt_s        = acc_r;
    count_nxt_s      = count_r;
    out_word_nxt_s   = out_word_r;
    out_nbytes_nxt_s = out_nbytes_r;
    slot_nxt_s       = slot_r;

    if (emit_s) begin
      acc_nxt_s        = {W{1'b0}};
      count_nxt_s      = {CNT_W{1'b0}};
      out_word_nxt_s   = acc_ins_s;
      out_nbytes_nxt_s = nbytes_s;
    end else if (in_accept_s) begin
      acc_nxt_s   = acc_ins_s;
      count_nxt_s = count_r + ONE_CNT;
    end else begin
      acc_nxt_s   = acc_r;
      count_nxt_s = count_r;
    end

    case (slot_r)
      SLOT_EMPTY: begin
        if (emit_s) begin
          slot_nxt_s = SLOT_FULL;
        end else begin
          slot_nxt_s = SLOT_EMPTY;
        end
      end
      SLOT_FULL: begin
        // A new word loading on the take edge keeps the slot full (no bubble).
        if (emit_s) begin
          slot_nxt_s = SLOT_FULL;
        end else if (out_take_s) begin
          slot_nxt_s = SLOT_EMPTY;
        end else begin
          slot_nxt_s = SLOT_FULL;
        end
      end
      default: begin
        slot_nxt_s = SLOT_EMPTY;
      end
    endcase
  end

  // State registers; reset discards any partial word and pending output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r       <= SLOT_EMPTY;
      acc_r        <= {W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      out_word_r   <= {W{1'b0}};
      out_nbytes_r <= {CNT_W{1'b0}};
    end else begin
      slot_r       <= slot_nxt_s;
      acc_r        <= acc_nxt_s;
      count_r      <= count_nxt_s;
      out_word_r   <= out_word_nxt_s;
      out_nbytes_r <= out_nbytes_nxt_s;
    end
  end

endmodule

// File: tb/tb_byte_merger.sv
// -----------------------------------------------------------------------------
// tb_byte_merger
// Directed bench for byte_merger: a vector table for handshake, flush and
// backpressure sequences, plus hand-written reset and streaming sequences.
// -----------------------------------------------------------------------------
module tb_byte_merger;

  logic clk;
  logic rst_n;

  byte_merger_if #(.N_BYTES(4), .CNT_W(3)) bus ();

  byte_merger #(.N_BYTES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  b;
    logic        v;
    logic        f;
    logic        r;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_w;
    logic [2:0]  e_nb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic v, input logic f, input logic r,
                     input logic e_ir, input logic e_ov, input logic [31:0] e_w,
                     input logic [2:0] e_nb);
    vec_t t;
    t.b = b; t.v = v; t.f = f; t.r = r;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_w = e_w; t.e_nb = e_nb;
    tbl.push_back(t);
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic f, input logic r);
    bus.in_byte   = b;
    bus.in_valid  = v;
    bus.flush     = f;
    bus.out_ready = r;
  endtask

  task automatic chk_out(input string tag, input logic e_ov, input logic [31:0] e_w,
                         input logic [2:0] e_nb);
    chk({tag, ".out_valid"},  {31'd0, bus.out_valid}, {31'd0, e_ov});
    chk({tag, ".out_word"},   bus.out_word, e_w);
    chk({tag, ".out_nbytes"}, {29'd0, bus.out_nbytes}, {29'd0, e_nb});
  endtask

  logic [7:0]  sb[64];
  logic [31:0] exp_w;

  initial begin
    // T2 basic packing
    add(8'h12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 3'd0);
    add(8'h34, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 3'd0);
    add(8'h56, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 3'd0);
    add(8'h78, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 3'd4);
    add(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 3'd4);
    // T4 flush without byte, flush on empty, flush with 3rd byte
    add(8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 3'd4);
    add(8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1234_5678, 3'd4);
    add(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAABB_0000, 3'd2);
    add(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hAABB_0000, 3'd2);
    add(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hAABB_0000, 3'd2);
    add(8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAABB_0000, 3'd2);
    add(8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAABB_0000, 3'd2);
    add(8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAABB_CC00, 3'd3);
    add(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAABB_CC00, 3'd3);
    // flush on the completing byte behaves like a normal completion
    add(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAABB_CC00, 3'd3);
    add(8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAABB_CC00, 3'd3);
    add(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hAABB_CC00, 3'd3);
    add(8'h04, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0102_0304, 3'd4);
    // T3 backpressure: DEADBEEF held while out_ready=0, byte 0x01 not lost
    add(8'hDE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0102_0304, 3'd4);
    add(8'hAD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0102_0304, 3'd4);
    add(8'hBE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0102_0304, 3'd4);
    add(8'hEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 3'd4);
    add(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'd4);
    add(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'd4);
    add(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'd4);
    add(8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 3'd4);
    add(8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 3'd4);
    add(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 3'd4);
    add(8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0102_0304, 3'd4);
    add(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0102_0304, 3'd4);
    add(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0102_0304, 3'd4);
    // flush together with a 2nd byte, then flush of a single byte
    add(8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0102_0304, 3'd4);
    add(8'h66, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5566_0000, 3'd2);
    add(8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5566_0000, 3'd2);
    add(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h7700_0000, 3'd1);
    add(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7700_0000, 3'd1);

    // T1: reset held with random inputs, then asynchronous release
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk_out("t1_reset", 1'b0, 32'h0000_0000, 3'd0);
      chk("t1_reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    end
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    #1 chk_out("t1_release", 1'b0, 32'h0000_0000, 3'd0);
    @(negedge clk);

    // Table-driven sequences (T2, T3, T4)
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].b, tbl[i].v, tbl[i].f, tbl[i].r);
      #1;
      chk($sformatf("vec%0d.in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].e_ir});
      @(posedge clk);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_w, tbl[i].e_nb);
      @(negedge clk);
    end

    // T5: 64 bytes streamed back-to-back, one word every 4 cycles
    for (int i = 0; i < 64; i++) sb[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 64; i++) begin
      drive(sb[i], 1'b1, 1'b0, 1'b1);
      #1;
      chk($sformatf("t5_b%0d.in_ready", i), {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("t5_b%0d.out_valid", i), {31'd0, bus.out_valid}, {31'd0, ((i % 4) == 3)});
      if ((i % 4) == 3) begin
        exp_w = {sb[i-3], sb[i-2], sb[i-1], sb[i]};
        chk($sformatf("t5_w%0d.out_word", i / 4), bus.out_word, exp_w);
        chk($sformatf("t5_w%0d.out_nbytes", i / 4), {29'd0, bus.out_nbytes}, 32'd4);
      end
      @(negedge clk);
    end

    // T6: reset after two bytes of a word, then a clean word
    drive(8'h99, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h88, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_out("t6_async_reset", 1'b0, 32'h0000_0000, 3'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk_out("t6_release", 1'b0, 32'h0000_0000, 3'd0);
    @(negedge clk);
    drive(8'h11, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 chk_out("t6_b0", 1'b0, 32'h0000_0000, 3'd0);
    @(negedge clk);
    drive(8'h22, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 chk_out("t6_b1", 1'b0, 32'h0000_0000, 3'd0);
    @(negedge clk);
    drive(8'h33, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 chk_out("t6_b2", 1'b0, 32'h0000_0000, 3'd0);
    @(negedge clk);
    drive(8'h44, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1 chk_out("t6_b3", 1'b1, 32'h1122_3344, 3'd4);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1 chk_out("t6_idle", 1'b0, 32'h1122_3344, 3'd4);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
